instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch port and the instruction memory. It takes the CPU's program-counter address, returns the 32-bit instruction on a hit in the same cycle, and stalls the CPU through `BUSYWAIT` while a missed block is fetched from instruction memory. Data width and stall semantics match the data-memory busywait protocol the CPU already uses.

## Interface
Parameters:
- `ADDR_W`, 10: byte-address width of `ADDRESS`.
- `BLOCKS`, 8: number of cache lines (power of two).
- `WORDS`, 4: 32-bit words per line (power of two).

Ports:
- `CLK`, input, 1: clock; all state changes on its rising edge.
- `RESET_N`, input, 1: reset, **asynchronous, active-low**.
- `READ`, input, 1: the CPU requests a fetch this cycle.
- `ADDRESS`, input, ADDR_W: the CPU byte address (the PC).
- `INSTRUCTION`, output, 32: the fetched instruction. Valid when `READ=1` and `BUSYWAIT=0`.
- `BUSYWAIT`, output, 1: stalls the CPU while high.
- `MEM_READ`, output, 1: block read request to instruction memory.
- `MEM_ADDRESS`, output, ADDR_W-log2(WORDS*4): block address sent to memory.
- `MEM_READDATA`, input, 32*WORDS: block data from memory. Word 0 occupies bits [31:0].
- `MEM_BUSYWAIT`, input, 1: memory is not ready.

## Operation
- **Address split (defaults):** offset [1:0] ignored; word [3:2]; index [6:4]; tag [9:7].
- **Per-line state:** `valid` (1 bit), `tag`, and the data block.
- **Hit:** `valid[index] && tag[index]==ADDRESS.tag`.
- **`INSTRUCTION`:** always the word selected by `word` from line `index`. This path is combinational.
- **FSM states:** `IDLE`, `FETCH`.
  - `IDLE`: `BUSYWAIT = READ && !hit`. If `READ && !hit`, latch `{tag,index}` into `miss_addr` and go to `FETCH`. Otherwise stay.
  - `FETCH`: `MEM_READ=1`, `MEM_ADDRESS=miss_addr`, `BUSYWAIT=1`.
    - On an edge with `MEM_BUSYWAIT=0`: write `MEM_READDATA` into line `miss_addr.index`, set its tag to `miss_addr.tag`, set `valid=1`, and go to `IDLE`.
    - Otherwise stay in `FETCH`.
- **Memory contract:** `MEM_BUSYWAIT` goes high combinationally from `MEM_READ` whenever data is not ready. `MEM_READDATA` is valid on the edge where `MEM_READ=1 && MEM_BUSYWAIT=0`.
- **Conflict misses:** a miss to an occupied line overwrites it. Read-only, so nothing is ever written back.
- **Address during a stall:** `ADDRESS` may change while `BUSYWAIT=1` with no effect on the fetch in progress, because the fill uses `miss_addr`. After the fill, the hit check uses the current `ADDRESS`.
- **`READ` dropped during `FETCH`:** the fill still completes.
- **Reset (any state, including mid-`FETCH`):**
  - All `valid` bits cleared; state returns to `IDLE`.
  - `MEM_READ=0`, `MEM_ADDRESS=0`, `miss_addr=0`.
  - While `RESET_N=0`, `BUSYWAIT=0` and `INSTRUCTION` is don't-care.
  - Data and tag arrays are not cleared.

## Timing
- **Hit:** zero-cycle latency. `INSTRUCTION` is valid in the same cycle and `BUSYWAIT=0`, so the CPU's PC advances on the next edge.
- **Miss** (memory ready after L cycles, L≥0):
  - Edge 0: `IDLE`→`FETCH`.
  - `MEM_READ` is high for L+1 cycles.
  - The line is written on the edge where `MEM_BUSYWAIT=0`.
  - The next cycle is `IDLE` with a hit, so `BUSYWAIT` falls.
  - Total `BUSYWAIT`-high cycles = L+2.
- **Reset:** asynchronous on assertion. Deassertion is sampled at the next `CLK` edge; the first fetch after that is a miss.

## Structure
- **Package `icache_pkg`:**
  - State enum `icache_state_t {IDLE, FETCH}`.
  - Derived localparams `WORD_W`, `INDEX_W`, `TAG_W`, `BLOCK_W`.
- **Sub-module `icache_line_array`:** holds the valid/tag/data storage, with one read port (index) and one write port (we, index, tag, block). Valid bits reset asynchronously.
- **Top level:** FSM, hit compare, word mux.

## Test plan
1. **Cold miss.** Reset, then `READ=1` with `ADDRESS=0x000`; the memory model has L=3 and block = {0x44,0x33,0x22,0x11}.
   - `MEM_READ` high for 4 cycles with `MEM_ADDRESS=0`.
   - `BUSYWAIT` high for 5 cycles.
   - Then `INSTRUCTION=0x11`.
2. **Sequential hits.** After test 1, read `ADDRESS` 0x004, 0x008, 0x00C.
   - `BUSYWAIT=0` throughout; `INSTRUCTION` = 0x22, 0x33, 0x44; `MEM_READ` stays 0.
3. **Conflict.** Read 0x000 (filled), then 0x080 (same index 0, tag 1), then 0x000.
   - Both later reads miss; `MEM_ADDRESS` = 0x08, then 0x00.
4. **Zero-latency memory.** L=0, miss at 0x010.
   - `MEM_READ` high for exactly 1 cycle; `BUSYWAIT` high for 2 cycles.
5. **Reset mid-fetch.** Pulse `RESET_N` low during `FETCH`.
   - `MEM_READ` and `BUSYWAIT` drop immediately.
   - A re-read of the same address misses again.
6. **Idle / changing address.** With `READ=0` on an invalid line, `BUSYWAIT=0` and `MEM_READ=0`. Changing `ADDRESS` during `FETCH` does not change `MEM_ADDRESS`.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and derived geometry for the direct-mapped instruction cache.
// The localparams describe the default geometry; the RTL recomputes from its own parameters.
package icache_pkg;

    typedef enum logic {IDLE, FETCH} icache_state_t;

    localparam int ICACHE_ADDR_W = 10;
    localparam int ICACHE_BLOCKS = 8;
    localparam int ICACHE_WORDS  = 4;

    localparam int WORD_W  = $clog2(ICACHE_WORDS);
    localparam int INDEX_W = $clog2(ICACHE_BLOCKS);
    localparam int TAG_W   = ICACHE_ADDR_W - INDEX_W - WORD_W - 2;
    localparam int BLOCK_W = 32 * ICACHE_WORDS;

    function automatic int tag_width(int addr_w, int blocks, int words);
        return addr_w - $clog2(blocks) - $clog2(words) - 2;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read port, one write port.
// Only the valid bits are reset; tags and data are qualified by valid.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int BLOCKS = ICACHE_BLOCKS,
    parameter int IDX_W  = INDEX_W,
    parameter int TG_W   = TAG_W,
    parameter int BLK_W  = BLOCK_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [TG_W-1:0]  rd_tag,
    output logic [BLK_W-1:0] rd_block,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TG_W-1:0]  wr_tag,
    input  logic [BLK_W-1:0] wr_block
);

    logic [BLOCKS-1:0] valid;
    logic [TG_W-1:0]   tag_mem  [BLOCKS];
    logic [BLK_W-1:0]  data_mem [BLOCKS];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_block;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_block = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, BUSYWAIT stall while a
// missed block is fetched from instruction memory.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int ADDR_W = ICACHE_ADDR_W,
    parameter int BLOCKS = ICACHE_BLOCKS,
    parameter int WORDS  = ICACHE_WORDS
) (
    input  logic                                 CLK,
    input  logic                                 RESET_N,
    input  logic                                 READ,
    input  logic [ADDR_W-1:0]                    ADDRESS,
    output logic [31:0]                          INSTRUCTION,
    output logic                                 BUSYWAIT,
    output logic                                 MEM_READ,
    output logic [ADDR_W-$clog2(WORDS*4)-1:0]    MEM_ADDRESS,
    input  logic [32*WORDS-1:0]                  MEM_READDATA,
    input  logic                                 MEM_BUSYWAIT
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(BLOCKS);
    localparam int TG_W   = tag_width(ADDR_W, BLOCKS, WORDS);
    localparam int BLK_W  = 32 * WORDS;
    localparam int MA_W   = TG_W + IDX_W;

    icache_state_t state, state_n;
    logic [MA_W-1:0] miss_addr, miss_addr_n;

    logic [WSEL_W-1:0] addr_word;
    logic [IDX_W-1:0]  addr_index;
    logic [TG_W-1:0]   addr_tag;
    logic              unused_byte_offset;

    logic              rd_valid;
    logic [TG_W-1:0]   rd_tag;
    logic [BLK_W-1:0]  rd_block;
    logic              hit;
    logic              fill_we;
    logic              busy;

    assign addr_word          = ADDRESS[WSEL_W+1:2];
    assign addr_index         = ADDRESS[IDX_W+WSEL_W+1:WSEL_W+2];
    assign addr_tag           = ADDRESS[ADDR_W-1:IDX_W+WSEL_W+2];
    assign unused_byte_offset = ^ADDRESS[1:0];

    icache_line_array #(
        .BLOCKS (BLOCKS),
        .IDX_W  (IDX_W),
        .TG_W   (TG_W),
        .BLK_W  (BLK_W)
    ) u_lines (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .rd_index (addr_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_block (rd_block),
        .we       (fill_we),
        .wr_index (miss_addr[IDX_W-1:0]),
        .wr_tag   (miss_addr[MA_W-1:IDX_W]),
        .wr_block (MEM_READDATA)
    );

    assign hit = rd_valid && (rd_tag == addr_tag);

    always_comb begin
        INSTRUCTION = rd_block[31:0];
        for (int w = 1; w < WORDS; w++) begin
            if (addr_word == w[WSEL_W-1:0]) begin
                INSTRUCTION = rd_block[w*32 +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state     <= state_n;
            miss_addr <= miss_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        miss_addr_n = miss_addr;
        busy        = 1'b0;
        MEM_READ    = 1'b0;
        fill_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (READ && !hit) begin
                    busy        = 1'b1;
                    miss_addr_n = {addr_tag, addr_index};
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_we = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Valid bits clear asynchronously, so an IDLE miss would otherwise stall during reset.
    assign BUSYWAIT    = busy & RESET_N;
    assign MEM_ADDRESS = (state == FETCH) ? miss_addr : '0;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural instruction memory of programmable latency.
module tb_instruction_cache;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         READ;
    logic [9:0]   ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int mem_cnt  = 0;

    logic [127:0] mem_blocks [64];

    instruction_cache dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .READ         (READ),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory becomes ready after lat cycles of continuous MEM_READ.
    always @(posedge CLK) begin
        if (MEM_READ && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
        else                          mem_cnt <= 0;
    end
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < lat);
    assign MEM_READDATA = mem_blocks[MEM_ADDRESS];

    task automatic run_fetch(input logic [9:0] addr, output int busy_n, output int rd_n,
                             output logic [5:0] maddr, output logic [31:0] instr,
                             output bit timed_out);
        busy_n = 0; rd_n = 0; maddr = '0; instr = '0; timed_out = 1'b1;
        READ = 1'b1;
        ADDRESS = addr;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                rd_n++;
                if (rd_n == 1) maddr = MEM_ADDRESS;
            end
            if (!BUSYWAIT) begin
                instr = INSTRUCTION;
                timed_out = 1'b0;
                break;
            end
            busy_n++;
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; READ = 1'b1; ADDRESS = 10'h000; lat = 3;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
        checks++;
        if (MEM_READ !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b expected 0", MEM_READ); end
        checks++;
        if (MEM_ADDRESS !== 6'h00) begin failures++; $display("FAIL reset_mem_address: got %h expected 00", MEM_ADDRESS); end
        @(posedge CLK); #1;
        RESET_N = 1'b1; READ = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_cold_miss();
        int b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        lat = 3;
        run_fetch(10'h000, b, r, ma, ins, to);
        checks++;
        if (to) begin failures++; $display("FAIL cold_timeout: got timeout expected completion"); end
        checks++;
        if (b != 5) begin failures++; $display("FAIL cold_busy_cycles: got %0d expected 5", b); end
        checks++;
        if (r != 4) begin failures++; $display("FAIL cold_mem_read_cycles: got %0d expected 4", r); end
        checks++;
        if (ma !== 6'h00) begin failures++; $display("FAIL cold_mem_address: got %h expected 00", ma); end
        checks++;
        if (ins !== 32'h11) begin failures++; $display("FAIL cold_instruction: got %h expected 00000011", ins); end
    endtask

    task automatic test_seq_hits();
        logic [9:0]  addrs [3];
        logic [31:0] exps  [3];
        int b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        addrs[0] = 10'h004; addrs[1] = 10'h008; addrs[2] = 10'h00C;
        exps[0]  = 32'h22;  exps[1]  = 32'h33;  exps[2]  = 32'h44;
        for (int k = 0; k < 3; k++) begin
            run_fetch(addrs[k], b, r, ma, ins, to);
            checks++;
            if (b != 0 || r != 0) begin failures++; $display("FAIL hit_stall[%0d]: got busy=%0d mem_read=%0d expected 0/0", k, b, r); end
            checks++;
            if (ins !== exps[k]) begin failures++; $display("FAIL hit_instruction[%0d]: got %h expected %h", k, ins, exps[k]); end
        end
    endtask

    task automatic test_conflict();
        int b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        lat = 2;
        run_fetch(10'h000, b, r, ma, ins, to);
        checks++;
        if (b != 0 || ins !== 32'h11) begin failures++; $display("FAIL conflict_prehit: got busy=%0d instr=%h expected 0/00000011", b, ins); end
        run_fetch(10'h080, b, r, ma, ins, to);
        checks++;
        if (b != 4 || r != 3) begin failures++; $display("FAIL conflict_miss1_cycles: got busy=%0d mem_read=%0d expected 4/3", b, r); end
        checks++;
        if (ma !== 6'h08) begin failures++; $display("FAIL conflict_miss1_addr: got %h expected 08", ma); end
        checks++;
        if (ins !== 32'hA000_0800) begin failures++; $display("FAIL conflict_miss1_instr: got %h expected a0000800", ins); end
        run_fetch(10'h000, b, r, ma, ins, to);
        checks++;
        if (b != 4 || ma !== 6'h00) begin failures++; $display("FAIL conflict_miss2: got busy=%0d addr=%h expected 4/00", b, ma); end
        checks++;
        if (ins !== 32'h11) begin failures++; $display("FAIL conflict_miss2_instr: got %h expected 00000011", ins); end
    endtask

    task automatic test_zero_latency();
        int b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        lat = 0;
        run_fetch(10'h010, b, r, ma, ins, to);
        checks++;
        if (b != 2) begin failures++; $display("FAIL zero_lat_busy: got %0d expected 2", b); end
        checks++;
        if (r != 1) begin failures++; $display("FAIL zero_lat_mem_read: got %0d expected 1", r); end
        checks++;
        if (ma !== 6'h01 || ins !== 32'hA000_0100) begin failures++; $display("FAIL zero_lat_data: got addr=%h instr=%h expected 01/a0000100", ma, ins); end
    endtask

    task automatic test_idle_addr_change();
        int bad, n, b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        READ = 1'b0; ADDRESS = 10'h020; bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) bad++;
            @(posedge CLK); #1;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL idle_no_read: got %0d stalled cycles expected 0", bad); end
        lat = 3; READ = 1'b1; ADDRESS = 10'h024;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin failures++; $display("FAIL idle_miss_detect: got busy=%b mem_read=%b expected 1/0", BUSYWAIT, MEM_READ); end
        @(posedge CLK); #1;
        ADDRESS = 10'h0A8;
        n = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!MEM_READ) break;
            n++;
            if (MEM_ADDRESS !== 6'h02) bad++;
            @(posedge CLK); #1;
        end
        checks++;
        if (n != 4) begin failures++; $display("FAIL stall_mem_read_cycles: got %0d expected 4", n); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_mem_address_held: got %0d wrong cycles expected 0", bad); end
        checks++;
        if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL after_fill_new_addr_miss: got busy=%b expected 1", BUSYWAIT); end
        @(posedge CLK); #1;
        run_fetch(10'h0A8, b, r, ma, ins, to);
        checks++;
        if (b != 4 || ma !== 6'h0A) begin failures++; $display("FAIL second_fill: got busy=%0d addr=%h expected 4/0a", b, ma); end
        checks++;
        if (ins !== 32'hA000_0A02) begin failures++; $display("FAIL second_fill_instr: got %h expected a0000a02", ins); end
    endtask

    task automatic test_reset_mid_fetch();
        int b, r; logic [5:0] ma; logic [31:0] ins; bit to;
        lat = 5; READ = 1'b1; ADDRESS = 10'h030;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (MEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin failures++; $display("FAIL midfetch_in_fetch: got mem_read=%b busy=%b expected 1/1", MEM_READ, BUSYWAIT); end
        #1 RESET_N = 1'b0;
        #1;
        checks++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin failures++; $display("FAIL midfetch_async_drop: got mem_read=%b busy=%b expected 0/0", MEM_READ, BUSYWAIT); end
        checks++;
        if (MEM_ADDRESS !== 6'h00) begin failures++; $display("FAIL midfetch_mem_address: got %h expected 00", MEM_ADDRESS); end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        lat = 1;
        run_fetch(10'h000, b, r, ma, ins, to);
        checks++;
        if (b != 3 || r != 2 || ma !== 6'h00) begin failures++; $display("FAIL post_reset_refill: got busy=%0d mem_read=%0d addr=%h expected 3/2/00", b, r, ma); end
        checks++;
        if (ins !== 32'h11) begin failures++; $display("FAIL post_reset_instr: got %h expected 00000011", ins); end
        run_fetch(10'h030, b, r, ma, ins, to);
        checks++;
        if (b != 3 || ma !== 6'h03 || ins !== 32'hA000_0300) begin failures++; $display("FAIL post_reset_same_addr: got busy=%0d addr=%h instr=%h expected 3/03/a0000300", b, ma, ins); end
    endtask

    initial begin
        for (int bk = 0; bk < 64; bk++) begin
            for (int w = 0; w < 4; w++) begin
                mem_blocks[bk][w*32 +: 32] = 32'hA000_0000 | (bk << 8) | w;
            end
        end
        mem_blocks[0] = {32'h44, 32'h33, 32'h22, 32'h11};
        RESET_N = 1'b0; READ = 1'b0; ADDRESS = '0;

        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_zero_latency();
        test_idle_addr_change();
        test_reset_mid_fetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
